factor_judge: RTL and testbench
===============================

Name: factor_judge

Overview:
- Answer-judging stage for the factorization game; sits directly upstream of the HP/state manager (JOIN) and drives its JUDG and WRONG inputs.
- During an open question it takes the player's two submitted factors and multiplies them with a sequential shift-add multiplier.
- It compares the product with the question's composite number and emits one-cycle verdict pulses.
- It also arbitrates against the opponent's "solved" notification and enforces a per-answer time limit.

Parameters:
- W, 8, bit width of each factor; TARGET is 2W bits.
- TIMEOUT, 1000, cycles allowed in WAIT without a submission before a timeout penalty; must be ≥ 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- QUE  in  1  level from the question stage; high while a question is open.
- TARGET  in  2W  composite number for the current question; sampled on QUE rise.
- FA_IN  in  W  first factor from the input module.
- FB_IN  in  W  second factor from the input module.
- SUBMIT  in  1  one-cycle pulse; FA_IN/FB_IN are valid in that cycle.
- OPP_DONE  in  1  one-cycle pulse; the opponent solved the question.
- JUDG  out  2  one-cycle verdict pulse: 01 = player correct, 10 = opponent first, 00 otherwise, 11 never.
- WRONG  out  2  one-cycle penalty pulse: 01 = wrong answer, 10 = timeout, 00 otherwise, 11 never.
- BUSY  out  1  high in MULT and CHECK; SUBMIT is ignored while high.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; JUDG=00, WRONG=00, BUSY=0; all internal registers cleared. Reset mid-MULT discards the answer with no pulse.
- All outputs are registered. JUDG and WRONG are never nonzero in the same cycle, and each pulse lasts exactly one cycle.
- States: IDLE, WAIT, MULT, CHECK.
- IDLE:
  - QUE rising edge (QUE=1 with previous QUE=0): latch TARGET, load timer=TIMEOUT, go to WAIT.
  - SUBMIT and OPP_DONE are ignored.
- WAIT:
  - OPP_DONE has priority: JUDG=10 next cycle, go to IDLE. A SUBMIT in the same cycle is dropped.
  - Else on SUBMIT: latch FA_IN/FB_IN, clear the product, load the iteration count=W, go to MULT.
  - Else the timer decrements each cycle. When it reaches 0: WRONG=10 next cycle, timer reloads to TIMEOUT, stay in WAIT. Timeouts repeat every TIMEOUT cycles until a submission is made.
- MULT:
  - Each cycle: if FB bit 0 is set, add FA to the product (2W bits, cannot overflow); then shift FA left and FB right.
  - After exactly W cycles, go to CHECK. The timer is frozen in MULT and CHECK.
- CHECK (one cycle): correct = (product == latched TARGET) AND FA ≥ 2 AND FB ≥ 2. Trivial factorizations (1×N) and zero factors are wrong.
  - Correct: JUDG=01, go to IDLE.
  - Wrong: WRONG=01, reload the timer, return to WAIT.
- Latency: SUBMIT in cycle t gives the JUDG or WRONG pulse visible in cycle t+W+2.
- OPP_DONE during MULT or CHECK:
  - Remember it in a pending flag.
  - If the answer in flight is correct, the player wins (JUDG=01) and the flag is cleared.
  - If it is wrong, emit WRONG=01, then in the following cycle JUDG=10 and go to IDLE. This cycle does not return to WAIT.
- QUE falling in WAIT, MULT or CHECK: abort to IDLE immediately with no pulse; any pending flag is cleared.
- QUE must fall and rise again to start the next question.
- TARGET changes while a question is open are ignored; only the value latched at QUE rise is used.

Test Plan:
- W=8, QUE rise with TARGET=143; SUBMIT FA=11, FB=13 at cycle t → JUDG=01 for exactly one cycle at t+10, BUSY high t+1..t+9, state returns to IDLE.
- TARGET=143; SUBMIT 1,143 → WRONG=01 at t+10. Then SUBMIT 12,12 → WRONG=01. Then SUBMIT 13,11 → JUDG=01. No JUDG on the wrong attempts.
- TARGET=143 in WAIT; OPP_DONE pulse together with SUBMIT 11,13 → JUDG=10 next cycle, no multiply, BUSY stays 0.
- OPP_DONE at t+3 during MULT with a correct answer → JUDG=01 only. Repeat with answer 2,2 → WRONG=01 at t+10, then JUDG=10 at t+11.
- TIMEOUT=20, QUE held high with no SUBMIT for 45 cycles → WRONG=10 pulses 20 and 40 cycles after entering WAIT, nothing else.
- RST=0 asserted asynchronously mid-MULT → all outputs 0 immediately, no pulse after release. A new QUE rise starts a clean round (143 = 11×13 → JUDG=01).

Source files
------------

// File: rtl/factor_judge_if.sv
// Handshake bundle between the question/input stages, factor_judge and JOIN.
// STATE carries the judge FSM encoding for observation only.
interface factor_judge_if #(
  parameter int W = 8
);
  logic             QUE;
  logic [2*W-1:0]   TARGET;
  logic [W-1:0]     FA_IN;
  logic [W-1:0]     FB_IN;
  logic             SUBMIT;
  logic             OPP_DONE;
  logic [1:0]       JUDG;
  logic [1:0]       WRONG;
  logic             BUSY;
  logic [1:0]       STATE;

  // SUBMIT and OPP_DONE are single-cycle pulses sampled on the rising clock;
  // SUBMIT is accepted only while BUSY is low and a question is open, and
  // JUDG/WRONG are single-cycle registered verdict pulses.
  modport master (
    output QUE, TARGET, FA_IN, FB_IN, SUBMIT, OPP_DONE,
    input  JUDG, WRONG, BUSY, STATE
  );

  modport slave (
    input  QUE, TARGET, FA_IN, FB_IN, SUBMIT, OPP_DONE,
    output JUDG, WRONG, BUSY, STATE
  );
endinterface

// File: rtl/factor_judge.sv
// Answer judge for the factorization game: shift-add multiply of the submitted
// factors, compare with the latched composite, arbitrate vs. the opponent, time out.
module factor_judge #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1000
) (
  input logic           CLK,
  input logic           RST,
  factor_judge_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_MULT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             que_q;
  logic [2*W-1:0]   target_q, target_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [2*W-1:0]   fa_q, fa_d;
  logic [W-1:0]     fb_q, fb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ok_q, ok_d;
  logic             pend_q, pend_d;
  logic             lose_q, lose_d;
  logic [1:0]       judg_q, judg_d;
  logic [1:0]       wrong_q, wrong_d;
  logic             busy_q, busy_d;
  logic             pend_now;
  logic             correct;

  assign pend_now = pend_q | bus.OPP_DONE;
  // Factors are shifted during MULT, so the >=2 test is captured at submit time.
  assign correct  = (prod_q == target_q) && ok_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    prod_d   = prod_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    ok_d     = ok_q;
    pend_d   = pend_q;
    lose_d   = lose_q;
    judg_d   = 2'b00;
    wrong_d  = 2'b00;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        lose_d = 1'b0;
        if (bus.QUE && !que_q) begin
          target_d = bus.TARGET;
          timer_d  = TW'(TIMEOUT);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.QUE) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else if (bus.OPP_DONE) begin
          judg_d  = 2'b10;
          state_d = S_IDLE;
        end else if (bus.SUBMIT) begin
          fa_d    = {{W{1'b0}}, bus.FA_IN};
          fb_d    = bus.FB_IN;
          prod_d  = '0;
          cnt_d   = CW'(W);
          ok_d    = (bus.FA_IN >= W'(2)) && (bus.FB_IN >= W'(2));
          state_d = S_MULT;
        end else if (timer_q == TW'(1)) begin
          wrong_d = 2'b10;
          timer_d = TW'(TIMEOUT);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_MULT: begin
        if (!bus.QUE) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          pend_d = pend_now;
          if (fb_q[0]) prod_d = prod_q + fa_q;
          fa_d  = fa_q << 1;
          fb_d  = fb_q >> 1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bus.QUE) begin
          pend_d  = 1'b0;
          lose_d  = 1'b0;
          state_d = S_IDLE;
        end else if (lose_q) begin
          // Second CHECK cycle after a wrong answer that lost the race.
          judg_d  = 2'b10;
          pend_d  = 1'b0;
          lose_d  = 1'b0;
          state_d = S_IDLE;
        end else if (correct) begin
          judg_d  = 2'b01;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wrong_d = 2'b01;
          timer_d = TW'(TIMEOUT);
          if (pend_now) begin
            lose_d = 1'b1;
            pend_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MULT) || (state_d == S_CHECK);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      que_q    <= 1'b0;
      target_q <= '0;
      prod_q   <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      ok_q     <= 1'b0;
      pend_q   <= 1'b0;
      lose_q   <= 1'b0;
      judg_q   <= 2'b00;
      wrong_q  <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      que_q    <= bus.QUE;
      target_q <= target_d;
      prod_q   <= prod_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      ok_q     <= ok_d;
      pend_q   <= pend_d;
      lose_q   <= lose_d;
      judg_q   <= judg_d;
      wrong_q  <= wrong_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.JUDG  = judg_q;
  assign bus.WRONG = wrong_q;
  assign bus.BUSY  = busy_q;
  assign bus.STATE = state_q;
endmodule

// File: tb/tb_factor_judge.sv
// Directed bench for factor_judge with W=8, TIMEOUT=20: verdict latency, wrong
// and trivial answers, opponent races, timeouts and asynchronous reset.
module tb_factor_judge;
  localparam int W  = 8;
  localparam int TO = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  factor_judge_if #(.W(W)) bus ();

  factor_judge #(.W(W), .TIMEOUT(TO)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic open_q(input logic [15:0] target);
    bus.QUE    = 1'b1;
    bus.TARGET = target;
    step();
    chk("open_state", 32'(bus.STATE), 32'(ST_WAIT));
    bus.TARGET = 16'd555;
  endtask

  task automatic close_q();
    bus.QUE = 1'b0;
    step();
  endtask

  // Submit a,b; optionally pulse OPP_DONE during MULT; check the verdict at t+W+2.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] ej, input logic [1:0] ew, input int opp_i);
    bus.FA_IN  = a;
    bus.FB_IN  = b;
    bus.SUBMIT = 1'b1;
    step();
    bus.SUBMIT = 1'b0;
    bus.FA_IN  = 8'($urandom_range(0, 255));
    bus.FB_IN  = 8'($urandom_range(0, 255));
    chk({tag, "_busy_start"}, 32'(bus.BUSY), 32'd1);
    for (int i = 1; i <= W; i++) begin
      if (i == opp_i) bus.OPP_DONE = 1'b1;
      step();
      bus.OPP_DONE = 1'b0;
      chk({tag, "_quiet"}, {28'd0, bus.JUDG, bus.WRONG}, 32'd0);
      chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    end
    step();
    chk({tag, "_judg"}, 32'(bus.JUDG), 32'(ej));
    chk({tag, "_wrong"}, 32'(bus.WRONG), 32'(ew));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.QUE      = 1'b0;
    bus.TARGET   = '0;
    bus.FA_IN    = '0;
    bus.FB_IN    = '0;
    bus.SUBMIT   = 1'b0;
    bus.OPP_DONE = 1'b0;
    step();
    step();
    chk("rst_judg", 32'(bus.JUDG), 32'd0);
    chk("rst_wrong", 32'(bus.WRONG), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_state", 32'(bus.STATE), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // IDLE ignores SUBMIT and OPP_DONE
    bus.SUBMIT   = 1'b1;
    bus.OPP_DONE = 1'b1;
    bus.FA_IN    = 8'd11;
    bus.FB_IN    = 8'd13;
    step();
    bus.SUBMIT   = 1'b0;
    bus.OPP_DONE = 1'b0;
    chk("idle_state", 32'(bus.STATE), 32'(ST_IDLE));
    chk("idle_out", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);
    step();
    chk("idle_out2", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);

    // 11 x 13 = 143, TARGET changed after latching
    open_q(16'd143);
    run("t1", 8'd11, 8'd13, 2'b01, 2'b00, -1);
    chk("t1_busy_end", 32'(bus.BUSY), 32'd0);
    chk("t1_state", 32'(bus.STATE), 32'(ST_IDLE));
    step();
    chk("t1_one_cycle", {28'd0, bus.JUDG, bus.WRONG}, 32'd0);
    step();
    chk("t1_no_requestion", 32'(bus.STATE), 32'(ST_IDLE));
    close_q();

    // wrong, trivial and retry
    open_q(16'd143);
    run("t2a", 8'd1, 8'd143, 2'b00, 2'b01, -1);
    chk("t2a_state", 32'(bus.STATE), 32'(ST_WAIT));
    step();
    chk("t2a_one_cycle", {28'd0, bus.JUDG, bus.WRONG}, 32'd0);
    run("t2b", 8'd12, 8'd12, 2'b00, 2'b01, -1);
    step();
    run("t2c", 8'd13, 8'd11, 2'b01, 2'b00, -1);
    chk("t2c_state", 32'(bus.STATE), 32'(ST_IDLE));
    close_q();

    // boundaries: 2x2, zero factor against TARGET=0, 255x255
    open_q(16'd4);
    run("b_2x2", 8'd2, 8'd2, 2'b01, 2'b00, -1);
    close_q();
    open_q(16'd0);
    run("b_zero", 8'd0, 8'd5, 2'b00, 2'b01, -1);
    close_q();
    open_q(16'd65025);
    run("b_max", 8'd255, 8'd255, 2'b01, 2'b00, -1);
    close_q();

    // opponent wins in WAIT; simultaneous SUBMIT dropped
    open_q(16'd143);
    bus.OPP_DONE = 1'b1;
    bus.SUBMIT   = 1'b1;
    bus.FA_IN    = 8'd11;
    bus.FB_IN    = 8'd13;
    step();
    bus.OPP_DONE = 1'b0;
    bus.SUBMIT   = 1'b0;
    chk("t3_judg", 32'(bus.JUDG), 32'(2'b10));
    chk("t3_busy", 32'(bus.BUSY), 32'd0);
    chk("t3_state", 32'(bus.STATE), 32'(ST_IDLE));
    step();
    chk("t3_after", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);
    close_q();

    // opponent during MULT: correct answer still wins
    open_q(16'd143);
    run("t4a", 8'd11, 8'd13, 2'b01, 2'b00, 3);
    step();
    chk("t4a_after", {28'd0, bus.JUDG, bus.WRONG}, 32'd0);
    close_q();

    // opponent during MULT with wrong answer: WRONG then JUDG=10
    open_q(16'd143);
    run("t4b", 8'd2, 8'd2, 2'b00, 2'b01, 3);
    chk("t4b_hold_state", 32'(bus.STATE), 32'(ST_CHECK));
    step();
    chk("t4b_judg", 32'(bus.JUDG), 32'(2'b10));
    chk("t4b_wrong", 32'(bus.WRONG), 32'd0);
    chk("t4b_state", 32'(bus.STATE), 32'(ST_IDLE));
    step();
    chk("t4b_after", {28'd0, bus.JUDG, bus.WRONG}, 32'd0);
    close_q();

    // timeout pulses at 20 and 40 cycles after entering WAIT
    open_q(16'd143);
    for (int n = 1; n <= 45; n++) begin
      step();
      chk("t5_judg", 32'(bus.JUDG), 32'd0);
      chk("t5_wrong", 32'(bus.WRONG), (n == 20 || n == 40) ? 32'(2'b10) : 32'd0);
    end
    close_q();

    // QUE fall mid-MULT aborts silently
    open_q(16'd143);
    bus.FA_IN  = 8'd11;
    bus.FB_IN  = 8'd13;
    bus.SUBMIT = 1'b1;
    step();
    bus.SUBMIT = 1'b0;
    step();
    bus.QUE = 1'b0;
    step();
    chk("abort_state", 32'(bus.STATE), 32'(ST_IDLE));
    for (int n = 0; n < 10; n++) begin
      step();
      chk("abort_quiet", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);
    end

    // asynchronous reset mid-MULT
    open_q(16'd143);
    bus.FA_IN  = 8'd11;
    bus.FB_IN  = 8'd13;
    bus.SUBMIT = 1'b1;
    step();
    bus.SUBMIT = 1'b0;
    step();
    step();
    chk("t6_busy_pre", 32'(bus.BUSY), 32'd1);
    #2;
    rst_n   = 1'b0;
    bus.QUE = 1'b0;
    #1;
    chk("t6_async", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);
    chk("t6_async_state", 32'(bus.STATE), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      chk("t6_quiet", {27'd0, bus.BUSY, bus.JUDG, bus.WRONG}, 32'd0);
    end
    open_q(16'd143);
    run("t6_clean", 8'd11, 8'd13, 2'b01, 2'b00, -1);
    close_q();

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
